fetch_sequencer: RTL and testbench

- Multi-cycle fetch controller for the SEQUENTIAL Y86-64 core.
- Reads instruction bytes one per cycle from a byte-wide instruction memory and assembles a 10-byte instruction word for the Fetch stage.
- Fetches only as many bytes as the decoded icode requires, hands the word to the downstream stage over a valid/ready handshake, then advances or redirects the PC.
- Stops on halt, on an invalid icode, or on an out-of-range address.

---
 rtl/fetch_sequencer.sv | 171 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Byte-serial fetch controller for the sequential Y86-64 core: assembles a 10-byte word per instruction.
// Optional FETCH_PERF_CNT_EN adds saturating accept/stall counters.
module fetch_sequencer #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [79:0]       current_instruction,
  output logic [ADDR_W-1:0] out_pc,
  output logic [3:0]        out_len,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              fetch_error,
  output logic [1:0]        err_code
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       instr_count,
  output logic [31:0]       stall_count
`endif
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH0, S_FETCHN, S_PRESENT, S_HALT, S_ERROR} state_t;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [79:0]       buf_q, buf_d;
  logic [3:0]        len_q, len_d, icode_q, icode_d, cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;

  function automatic logic [3:0] len_of(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:        len_of = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len_of = 4'd2;
      4'h3, 4'h4, 4'h5:        len_of = 4'd10;
      4'h7, 4'h8:              len_of = 4'd9;
      default:                 len_of = 4'd1;
    endcase
  endfunction

  logic       pc_oob, len_oob, accept;
  logic [3:0] len_b0, len_cur;
  logic [6:0] lsb;

  // cnt_q counts the capture slot: at cnt=k byte k-1 arrives and address PC+k may be issued.
  assign pc_oob  = pc_q >= LIMIT;
  assign len_b0  = len_of(mem_rdata[7:4]);
  assign len_oob = (pc_q + ADDR_W'(len_b0) - ADDR_W'(1)) >= LIMIT;
  assign len_cur = (cnt_q == 4'd1) ? len_b0 : len_q;
  assign lsb     = 7'd80 - {cnt_q, 3'b000};
  assign accept  = (state_q == S_PRESENT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      icode_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      icode_q <= icode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    len_d   = len_q;
    icode_d = icode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        pc_d    = start_pc;
        state_d = S_FETCH0;
      end
      S_FETCH0: if (pc_oob) begin
        err_d   = 2'd2;
        state_d = S_ERROR;
      end else begin
        buf_d   = '0;
        cnt_d   = 4'd1;
        state_d = S_FETCHN;
      end
      S_FETCHN: begin
        buf_d[lsb +: 8] = mem_rdata;
        if (cnt_q == 4'd1) begin
          icode_d = mem_rdata[7:4];
          len_d   = len_b0;
        end
        if (cnt_q == 4'd1 && len_oob) begin
          err_d   = 2'd2;
          state_d = S_ERROR;
        end else if (cnt_q == len_cur) begin
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_PRESENT: if (accept) begin
        if (icode_q == 4'h0) begin
          state_d = S_HALT;
        end else if (icode_q > 4'hB) begin
          err_d   = 2'd1;
          state_d = S_ERROR;
        end else begin
          pc_d    = redirect_valid ? redirect_pc : pc_q + ADDR_W'(len_q);
          state_d = S_FETCH0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_FETCH0: if (!pc_oob) begin
        mem_rd   = 1'b1;
        mem_addr = pc_q;
      end
      S_FETCHN: if ((cnt_q == 4'd1) ? (!len_oob && len_b0 > 4'd1) : (cnt_q < len_q)) begin
        mem_rd   = 1'b1;
        mem_addr = pc_q + ADDR_W'(cnt_q);
      end
      default: ;
    endcase
  end

  assign out_valid           = state_q == S_PRESENT;
  assign halted              = state_q == S_HALT;
  assign fetch_error         = state_q == S_ERROR;
  assign err_code            = err_q;
  assign current_instruction = buf_q;
  assign out_pc              = pc_q;
  assign out_len             = len_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_q, stall_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && instr_cnt_q != 32'hFFFF_FFFF) instr_cnt_q <= instr_cnt_q + 32'd1;
      if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
  assign instr_count = instr_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: program-level reference model, randomized back-pressure and redirects.
module tb_fetch_sequencer;
  localparam int MB = 1024;
  localparam int LEN_TBL [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

  logic        clk = 1'b0;
  logic        reset, start, out_ready, redirect_valid;
  logic [63:0] start_pc, redirect_pc, mem_addr, out_pc;
  logic        mem_rd, out_valid, halted, fetch_error;
  logic [7:0]  mem_rdata;
  logic [79:0] current_instruction;
  logic [3:0]  out_len;
  logic [1:0]  err_code;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_count, stall_count;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .current_instruction(current_instruction), .out_pc(out_pc), .out_len(out_len),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fetch_error(fetch_error), .err_code(err_code)
`ifdef FETCH_PERF_CNT_EN
    , .instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  logic [7:0] mem [MB];
  int rd_count = 0, oob_reads = 0;

  always @(posedge clk) begin
    if (mem_rd) begin
      rd_count <= rd_count + 1;
      if (mem_addr < 64'(MB)) mem_rdata <= mem[int'(mem_addr)];
      else begin
        oob_reads <= oob_reads + 1;
        mem_rdata <= 8'h00;
      end
    end
  end

  typedef struct { logic [79:0] w; logic [63:0] pc; logic [3:0] len; } item_t;
  item_t       exp_q[$];
  logic [79:0] act_w[$];
  logic [63:0] act_pc[$];
  int          total = 0, bad = 0, accepted = 0, stall_seen = 0;
  bit          free_run = 1'b1;
  logic        rv [64];
  logic [63:0] rp [64];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    item_t e, prv;
    bit hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      if (halted || fetch_error) chk("no_read_terminal", mem_rd, 0);
      if (out_valid && exp_q.size() == 0 && !free_run) chk("no_extra_valid", out_valid, 0);
      if (out_valid) begin
        chk("no_read_present", mem_rd, 0);
        if (hold) begin
          chk("stable_word", current_instruction, prv.w);
          chk("stable_pc", out_pc, prv.pc);
          chk("stable_len", out_len, prv.len);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_accept: pc %0h with empty scoreboard", out_pc);
          end else begin
            e = exp_q.pop_front();
            chk("word", current_instruction, e.w);
            chk("pc", out_pc, e.pc);
            chk("len", out_len, e.len);
            act_w.push_back(current_instruction);
            act_pc.push_back(out_pc);
            accepted++;
          end
          hold = 1'b0;
        end else begin
          stall_seen++;
          hold = 1'b1;
          prv.w = current_instruction;
          prv.pc = out_pc;
          prv.len = out_len;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    reset = 1'b0;
    act_w.delete();
    act_pc.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_word"}, current_instruction, 0);
    chk({tag, "_out_pc"}, out_pc, 0);
    chk({tag, "_out_len"}, out_len, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fetch_error"}, fetch_error, 0);
    chk({tag, "_err_code"}, err_code, 0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_instr_count"}, instr_count, 0);
    chk({tag, "_stall_count"}, stall_count, 0);
`endif
  endtask

  task automatic gen_redir(input int pct);
    for (int i = 0; i < 64; i++) begin
      rv[i] = $urandom_range(0, 99) < pct;
      rp[i] = ($urandom_range(0, 9) == 0) ? 64'(MB + $urandom_range(0, 200)) : 64'($urandom_range(0, MB - 1));
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
  endtask

  // outcome: 0 none (word limit reached), 1 halt, 2 invalid icode, 3 out of range
  task automatic run_prog(input logic [63:0] spc, input int rdy_pct, input int maxw, input int hold_n, input bit rst);
    item_t it;
    logic [63:0] pc;
    int nw, outcome, reads, acc_i, cyc, hold_left, L, rd_base, acc_base, st_base;
    bit exp_h, exp_e;
    if (rst) do_reset();
    exp_q.delete();
    pc = spc; nw = 0; outcome = 0; reads = 0;
    for (int i = 0; i < maxw; i++) begin
      if (pc >= 64'(MB)) begin outcome = 3; break; end
      L = LEN_TBL[mem[int'(pc)] >> 4];
      reads++;
      if (pc + 64'(L) - 64'd1 >= 64'(MB)) begin outcome = 3; break; end
      reads += L - 1;
      it.w = '0;
      for (int k = 0; k < L; k++) it.w[79 - 8 * k -: 8] = mem[int'(pc) + k];
      it.pc = pc;
      it.len = 4'(L);
      exp_q.push_back(it);
      nw++;
      if ((mem[int'(pc)] >> 4) == 0) begin outcome = 1; break; end
      if ((mem[int'(pc)] >> 4) > 11) begin outcome = 2; break; end
      pc = rv[i] ? rp[i] : pc + 64'(L);
    end
    free_run = (outcome == 0);
    rd_base = rd_count; acc_base = accepted; st_base = stall_seen;
    start_pc = spc;
    start = 1'b1;
    step();
    start = 1'b0;
    acc_i = 0; cyc = 0; hold_left = hold_n;
    while (acc_i < nw && cyc < 6000) begin
      if (out_valid && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else out_ready = $urandom_range(0, 99) < rdy_pct;
      if (out_valid && out_ready) begin
        redirect_valid = rv[acc_i];
        redirect_pc = rp[acc_i];
        acc_i++;
      end else begin
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc = {$urandom, $urandom};
      end
      step();
      cyc++;
    end
    if (cyc >= 6000) begin
      total++;
      bad++;
      $display("FAIL timeout: accepted %0d of %0d words", acc_i, nw);
    end
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    repeat (6) step();
    if (outcome != 0) begin
      exp_h = (outcome == 1);
      exp_e = (outcome >= 2);
      chk("words_done", accepted - acc_base, nw);
      chk("end_valid", out_valid, 0);
      chk("end_halted", halted, exp_h);
      chk("end_fetch_error", fetch_error, exp_e);
      chk("end_err_code", err_code, exp_e ? outcome - 1 : 0);
      chk("read_count", rd_count - rd_base, reads);
`ifdef FETCH_PERF_CNT_EN
      chk("instr_count", instr_count, nw);
      chk("stall_count", stall_count, stall_seen - st_base);
`endif
      rd_base = rd_count;
      start_pc = 64'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("sticky_halted", halted, exp_h);
      chk("sticky_fetch_error", fetch_error, exp_e);
      chk("sticky_no_reads", rd_count - rd_base, 0);
    end
  endtask

  task automatic latency(input logic [7:0] b0, input int exp_c);
    int c;
    do_reset();
    free_run = 1'b1;
    clear_mem();
    mem[0] = b0;
    start_pc = 64'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    #2;
    chk("cycle0_mem_rd", mem_rd, 1);
    chk("cycle0_mem_addr", mem_addr, 0);
    c = 0;
    while (!out_valid && c < 40) begin
      @(posedge clk);
      #2;
      c++;
      if (c == 1) chk("cycle1_mem_rd", mem_rd, exp_c > 2);
    end
    chk("latency", c, exp_c);
  endtask

  initial begin
    int rb;
    fork monitor(); join_none
    do_reset();
    #3;
    check_zero("reset");

    clear_mem();
    mem[0] = 8'h60; mem[1] = 8'h03; mem[2] = 8'h20; mem[3] = 8'h03;
    mem[4] = 8'h40; mem[5] = 8'h03; mem[13] = 8'h0F;
    mem[14] = 8'h10; mem[15] = 8'h10; mem[16] = 8'h00;
    gen_redir(0);
    run_prog(64'd0, 100, 20, 0, 1'b1);
    if (act_w.size() == 6) begin
      chk("seq_pc4", act_pc[2], 64'd4);
      chk("seq_word4", act_w[2], 80'h4003000000000000000F);
      chk("seq_last_pc", act_pc[5], 64'd16);
    end else begin
      total++;
      bad++;
      $display("FAIL seq_count: got %0d words expected 6", act_w.size());
    end

    latency(8'h10, 2);
    latency(8'h30, 11);

    clear_mem();
    mem[0] = 8'h70; mem[1] = 8'h20;
    mem[32] = 8'h10; mem[33] = 8'h00;
    gen_redir(0);
    rv[0] = 1'b1;
    rp[0] = 64'h20;
    run_prog(64'd0, 100, 20, 5, 1'b1);
    if (act_pc.size() >= 2) chk("redirect_pc", act_pc[1], 64'h20);
    else begin
      total++;
      bad++;
      $display("FAIL redirect_count: got %0d words expected 3", act_pc.size());
    end
`ifdef FETCH_PERF_CNT_EN
    chk("stall_five", stall_count, 5);
`endif

    clear_mem();
    mem[0] = 8'hC0;
    gen_redir(0);
    run_prog(64'd0, 100, 20, 0, 1'b1);

    clear_mem();
    mem[1018] = 8'h30;
    run_prog(64'd1018, 100, 20, 0, 1'b1);
    run_prog(64'd2000, 100, 20, 0, 1'b1);

    clear_mem();
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[9] = 8'h55; mem[10] = 8'h00;
    do_reset();
    free_run = 1'b1;
    start_pc = 64'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    step();
    #2;
    check_zero("midreset");
    rb = rd_count;
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("midreset_no_reads", rd_count - rb, 0);
    gen_redir(0);
    run_prog(64'd0, 100, 20, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < MB; i++) begin
        rb = $urandom_range(0, 99);
        mem[i] = {(rb < 3) ? 4'h0 : (rb < 6) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(1, 11)),
                  4'($urandom_range(0, 15))};
      end
      gen_redir(20);
      run_prog(64'($urandom_range(0, MB - 1)), $urandom_range(30, 100), 25, $urandom_range(0, 3), 1'b1);
    end

    chk("no_oob_reads", oob_reads, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
